wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two completion sources.
  - Requester 0: ALU/jump path, whose write value is the ALU result or the link PC.
  - Requester 1: load path, carrying loaded data.
- Sits between the execute/memory stages and the register file, replacing direct drive of write_data/write_reg/write_enable.
- Keeps a per-register pending scoreboard so decode can stall on in-flight destinations.

Parameters:
- XLEN, 64, data width of write-back values.
- NREG, 32, number of architectural registers.
- AW, 5, register address width; must equal log2(NREG).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- alu_valid  input  1  requester 0 has a result
- alu_reg  input  AW  requester 0 destination
- alu_data  input  XLEN  requester 0 value
- alu_ready  output  1  requester 0 accepted this cycle
- ld_valid  input  1  requester 1 has a result
- ld_reg  input  AW  requester 1 destination
- ld_data  input  XLEN  requester 1 value
- ld_ready  output  1  requester 1 accepted this cycle
- issue_valid  input  1  decode issued an instruction with a destination
- issue_reg  input  AW  destination of the issued instruction
- flush  input  1  pipeline flush
- write_enable  output  1  register-file write strobe
- write_reg  output  AW  register-file write address
- write_data  output  XLEN  register-file write data
- pending  output  NREG  scoreboard; bit r=1 means register r has an in-flight producer
- idle  output  1  no pending bits and no write in the output stage

Behaviour:
- Reset: while reset==0 at a clk edge:
  - write_enable=0, write_reg=0, write_data=0.
  - pending=0, last_grant=1, so requester 0 wins the first contention.
  - alu_ready=ld_ready=0 during reset.
- Arbitration (combinational ready):
  - Exactly one requester is granted per cycle.
  - Only alu_valid: alu_ready=1. Only ld_valid: ld_ready=1.
  - Both valid: grant the requester not equal to last_grant (round-robin).
  - ready never asserts without the matching valid.
  - last_grant updates only on an accepted handshake.
- Output stage (registered, latency 1):
  - An accepted request in cycle N appears on write_reg/write_data in cycle N+1.
  - write_enable=1 in cycle N+1 only if the accepted reg!=0.
  - A write to x0 is accepted (ready=1) but produces write_enable=0; write_reg/write_data are still loaded.
  - With no handshake, write_enable=0 the next cycle; write_reg/write_data hold their last values.
- Scoreboard:
  - Set: issue_valid && issue_reg!=0 sets pending[issue_reg] at the clk edge.
  - Clear: an accepted handshake clears pending[reg] at the same edge, i.e. at acceptance, not at the output write.
  - Set and clear of the same register in the same cycle: set wins (a newer producer exists).
  - pending[0] is always 0.
- Flush:
  - flush==1 at an edge: pending=0 and write_enable=0 next cycle; ready outputs forced to 0 that cycle.
  - issue_valid in the same cycle as flush is ignored.
  - last_grant is unchanged.
- idle = (pending==0) && !write_enable.
- Reset mid-operation: the in-flight output write is dropped (write_enable=0 next edge) and the scoreboard is cleared.
- Scoreboard errors are not flagged:
  - A completion for a non-pending register is accepted normally.
  - Re-issue to an already-pending register leaves the bit set.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_reg (AW) and fwd_data (XLEN).
  - These are combinational copies of the accepted request in the acceptance cycle.
  - fwd_valid = accepted && reg!=0, so execute can forward the value one cycle before the register-file write.
  - fwd_valid=0 during flush and during reset.
- Undefined: these ports do not exist; completed values are visible only after the register-file write.

Test Plan:
- ALU-only write: issue x5; next cycle alu_valid, reg=5, data=0xDEAD.
  - Required: alu_ready=1; next cycle write_enable=1, write_reg=5, write_data=0xDEAD; pending[5] 1->0; idle=1 after.
- Contention: both valid for 4 consecutive cycles (alu reg=1, ld reg=2) after reset.
  - Required grants: ALU, LD, ALU, LD; each non-granted ready=0.
- x0 write: ld_valid, reg=0, data=0x1234.
  - Required: ld_ready=1, write_enable=0 next cycle; pending unchanged.
- Same-cycle set/clear: pending[7]=1; issue_reg=7 and alu completion reg=7 in the same cycle.
  - Required: pending[7]=1 after the edge; write of x7 occurs next cycle.
- Flush: pending={x3,x4}, ld_valid reg=3 with flush=1.
  - Required: ld_ready=0, pending=0, write_enable=0 next cycle, idle=1.
- Reset mid-write: handshake in cycle N, reset=0 in cycle N.
  - Required: write_enable=0 at N+1, pending=0; after release, the first contention grants ALU.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between two completion sources:
//   requester 0 : ALU/jump path (ALU result or link PC)
//   requester 1 : load path (loaded data)
// Round-robin arbitration picks one accepted request per cycle. The winner is
// registered into the write-back output stage, so the latency is one cycle.
// A per-register pending scoreboard lets decode stall on in-flight destinations.
//
// Optional feature (macro WB_FWD_EN): adds fwd_valid/fwd_reg/fwd_data. These are
// combinational copies of the accepted request in its acceptance cycle, so that
// execute can forward the value one cycle before the register-file write.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   alu_valid/reg/data  requester 0 request;  alu_ready = accepted this cycle
//   ld_valid/reg/data   requester 1 request;  ld_ready  = accepted this cycle
//   issue_valid/reg     decode issued an instruction with a destination
//   flush               pipeline flush (clears scoreboard, drops acceptance)
//   write_enable/reg/data  register-file write port
//   pending             scoreboard, bit r = register r has an in-flight producer
//   idle                no pending bits and no write in the output stage
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_reg,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_reg,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_reg,
  input  logic            flush,
  output logic            write_enable,
  output logic [AW-1:0]   write_reg,
  output logic [XLEN-1:0] write_data,
  output logic [NREG-1:0] pending,
  output logic            idle
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_reg,
  output logic [XLEN-1:0] fwd_data
`endif
);

  // Which requester won the most recent accepted handshake.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_e;

  grant_e          last_grant;
  logic            accept;
  logic [AW-1:0]   sel_reg;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] pending_next;

  // Arbitration. Nothing is accepted while in reset or flushing, which also
  // keeps last_grant and the output stage untouched by those cycles.
  // NOTE: every signal assigned in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (reset && !flush) begin
      if (alu_valid && ld_valid) begin
        // Contention: grant whoever did not win last time.
        if (last_grant == GRANT_LD) alu_ready = 1'b1;
        else                        ld_ready  = 1'b1;
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  assign accept   = alu_ready | ld_ready;
  assign sel_reg  = ld_ready ? ld_reg  : alu_reg;
  assign sel_data = ld_ready ? ld_data : alu_data;

  // Scoreboard update. Clear is applied before set so that a newer producer
  // issued in the same cycle as an older completion keeps the bit set.
  always_comb begin
    pending_next = pending;
    if (accept) pending_next[sel_reg] = 1'b0;
    if (issue_valid && (issue_reg != '0)) pending_next[issue_reg] = 1'b1;
    if (flush) pending_next = '0;
    pending_next[0] = 1'b0;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      pending      <= '0;
      last_grant   <= GRANT_LD;  // requester 0 wins the first contention
    end else begin
      // A write to x0 is accepted and latched but never strobes the file.
      write_enable <= accept && (sel_reg != '0);
      if (accept) begin
        write_reg  <= sel_reg;
        write_data <= sel_data;
        last_grant <= ld_ready ? GRANT_LD : GRANT_ALU;
      end
      pending <= pending_next;
    end
  end

  assign idle = (pending == '0) && !write_enable;

`ifdef WB_FWD_EN
  // accept is already forced low during reset and flush.
  assign fwd_valid = accept && (sel_reg != '0);
  assign fwd_reg   = sel_reg;
  assign fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed testbench for wb_port_arbiter. Inputs change 1 ns after the rising
// edge; combinational readies are sampled 1 ns later, registered outputs 1 ns
// after the following edge.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [AW-1:0]   alu_reg;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [AW-1:0]   ld_reg;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            issue_valid;
  logic [AW-1:0]   issue_reg;
  logic            flush;
  logic            write_enable;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  logic [NREG-1:0] pending;
  logic            idle;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [AW-1:0]   fwd_reg;
  logic [XLEN-1:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_valid     (ld_valid),
    .ld_reg       (ld_reg),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .flush        (flush),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending      (pending),
    .idle         (idle)
`ifdef WB_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    alu_valid   = 1'b0;
    alu_reg     = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_reg      = '0;
    ld_data     = '0;
    issue_valid = 1'b0;
    issue_reg   = '0;
    flush       = 1'b0;

    // ---- Reset state; readies stay low while reset is asserted ----
    tick();
    tick();
    alu_valid = 1'b1;
    ld_valid  = 1'b1;
    settle();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_we", write_enable, 0);
    check("rst_wreg", write_reg, 0);
    check("rst_wdata", write_data, 0);
    check("rst_pending", pending, 0);
    check("rst_idle", idle, 1);

    // ---- Contention: ALU, LD, ALU, LD ----
    reset    = 1'b1;
    alu_reg  = 5'd1;
    alu_data = 64'hA1;
    ld_reg   = 5'd2;
    ld_data  = 64'hB2;
    settle();
    check("c0_alu_ready", alu_ready, 1);
    check("c0_ld_ready", ld_ready, 0);
    tick();
    check("c0_wreg", write_reg, 1);
    check("c0_wdata", write_data, 64'hA1);
    check("c0_we", write_enable, 1);
    check("c1_alu_ready", alu_ready, 0);
    check("c1_ld_ready", ld_ready, 1);
    tick();
    check("c1_wreg", write_reg, 2);
    check("c1_wdata", write_data, 64'hB2);
    check("c2_alu_ready", alu_ready, 1);
    check("c2_ld_ready", ld_ready, 0);
    tick();
    check("c2_wreg", write_reg, 1);
    check("c3_alu_ready", alu_ready, 0);
    check("c3_ld_ready", ld_ready, 1);
    tick();
    check("c3_wreg", write_reg, 2);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    tick();
    check("c_we_drop", write_enable, 0);
    check("c_idle", idle, 1);

    // ---- ALU-only write to x5 ----
    issue_valid = 1'b1;
    issue_reg   = 5'd5;
    tick();
    check("alu_pend_set", pending, 32'h0000_0020);
    check("alu_not_idle", idle, 0);
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_reg     = 5'd5;
    alu_data    = 64'hDEAD;
    settle();
    check("alu_ready", alu_ready, 1);
    check("alu_ld_ready", ld_ready, 0);
    tick();
    check("alu_we", write_enable, 1);
    check("alu_wreg", write_reg, 5);
    check("alu_wdata", write_data, 64'hDEAD);
    check("alu_pend_clr", pending, 0);
    alu_valid = 1'b0;
    tick();
    check("alu_we_drop", write_enable, 0);
    check("alu_wreg_hold", write_reg, 5);
    check("alu_wdata_hold", write_data, 64'hDEAD);
    check("alu_idle", idle, 1);

    // ---- x0 write via load path; pending x9 must be untouched ----
    issue_valid = 1'b1;
    issue_reg   = 5'd9;
    tick();
    issue_valid = 1'b0;
    ld_valid    = 1'b1;
    ld_reg      = 5'd0;
    ld_data     = 64'h1234;
    settle();
    check("x0_ld_ready", ld_ready, 1);
    tick();
    check("x0_we", write_enable, 0);
    check("x0_wreg", write_reg, 0);
    check("x0_wdata", write_data, 64'h1234);
    check("x0_pending", pending, 32'h0000_0200);
    ld_valid = 1'b0;

    // ---- Issue to x0 never sets pending[0] ----
    issue_valid = 1'b1;
    issue_reg   = 5'd0;
    tick();
    check("x0_issue", pending, 32'h0000_0200);

    // ---- Same-cycle set/clear of x7: set wins ----
    issue_reg = 5'd7;
    tick();
    check("sc_pend_pre", pending, 32'h0000_0280);
    alu_valid = 1'b1;
    alu_reg   = 5'd7;
    alu_data  = 64'h77;
    settle();
    check("sc_alu_ready", alu_ready, 1);
    tick();
    check("sc_pend_post", pending, 32'h0000_0280);
    check("sc_we", write_enable, 1);
    check("sc_wreg", write_reg, 7);
    check("sc_wdata", write_data, 64'h77);
    issue_valid = 1'b0;
    alu_valid   = 1'b0;

    // ---- Flush with pending {x3,x4} plus x7,x9; issue in flush ignored ----
    issue_valid = 1'b1;
    issue_reg   = 5'd3;
    tick();
    issue_reg = 5'd4;
    tick();
    check("fl_pend_pre", pending, 32'h0000_0298);
    issue_reg = 5'd5;
    ld_valid  = 1'b1;
    ld_reg    = 5'd3;
    ld_data   = 64'h33;
    flush     = 1'b1;
    settle();
    check("fl_ld_ready", ld_ready, 0);
    check("fl_alu_ready", alu_ready, 0);
    tick();
    check("fl_pending", pending, 0);
    check("fl_we", write_enable, 0);
    check("fl_idle", idle, 1);
    flush       = 1'b0;
    issue_valid = 1'b0;

    // last_grant was ALU before the flush and must still be: LD wins now.
    alu_valid = 1'b1;
    alu_reg   = 5'd1;
    alu_data  = 64'hA1;
    settle();
    check("fl_lg_ld_ready", ld_ready, 1);
    check("fl_lg_alu_ready", alu_ready, 0);
    tick();
    check("fl_lg_wreg", write_reg, 3);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;

    // ---- Reset mid-operation ----
    issue_valid = 1'b1;
    issue_reg   = 5'd6;
    tick();
    check("rm_pend_pre", pending, 32'h0000_0040);
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_reg     = 5'd6;
    alu_data    = 64'h66;
    reset       = 1'b0;
    settle();
    check("rm_alu_ready", alu_ready, 0);
    tick();
    check("rm_we", write_enable, 0);
    check("rm_pending", pending, 0);
    check("rm_wreg", write_reg, 0);
    check("rm_wdata", write_data, 0);
    // last_grant was LD before reset, reset forces it back so ALU wins.
    reset    = 1'b1;
    alu_reg  = 5'd1;
    alu_data = 64'hA1;
    ld_valid = 1'b1;
    ld_reg   = 5'd2;
    ld_data  = 64'hB2;
    settle();
    check("rm_first_alu", alu_ready, 1);
    check("rm_first_ld", ld_ready, 0);
    tick();
    check("rm_first_wreg", write_reg, 1);
    check("rm_first_we", write_enable, 1);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
